// File: rtl/mem_pkg.sv
// Shared types for the byte-serial memory responder: access widths, FSM states,
// and the width-to-byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    BITS8  = 2'd0,
    BITS16 = 2'd1,
    BITS32 = 2'd2
  } MemWidth;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_ACCESS  = 2'd1,
    RSP_RESPOND = 2'd2
  } ResponderState;

  // Reserved width 3 maps to one byte so the range check stays well-defined;
  // it is flagged as an error separately.
  function automatic logic [2:0] width_to_nbytes(MemWidth w);
    case (w)
      BITS8:   width_to_nbytes = 3'd1;
      BITS16:  width_to_nbytes = 3'd2;
      BITS32:  width_to_nbytes = 3'd4;
      default: width_to_nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes to 32 bits.
module mem_load_extend (
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  input  logic        is_signed,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = data;
    case (nbytes)
      3'd1:    rdata = {{24{is_signed & data[7]}}, data[7:0]};
      3'd2:    rdata = {{16{is_signed & data[15]}}, data[15:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/mem_byte_responder.sv
// Serialises one 8/16/32-bit load/store request into byte-wide RAM accesses
// (little-endian) and returns extended load data with a one-cycle response pulse.
module mem_byte_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned RAM_AW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] ST_IDLE    = RSP_IDLE;
  localparam logic [1:0] ST_ACCESS  = RSP_ACCESS;
  localparam logic [1:0] ST_RESPOND = RSP_RESPOND;

  logic [1:0]        state_q, state_d;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       bytes_q;
  logic [2:0]        nbytes_q;
  logic [1:0]        idx_q;
  logic              write_q;
  logic              signed_q;
  logic              err_q;

  logic [2:0]  req_nbytes;
  logic [32:0] req_last;
  logic        req_err;
  logic        last_byte;
  logic [31:0] ext_rdata;

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_nbytes = width_to_nbytes(MemWidth'(req_width));
    req_last   = {1'b0, req_addr} + {30'd0, req_nbytes} - 33'd1;
    req_err    = (req_width == 2'd3) || (req_last >= 33'(MEM_BYTES));
  end

  assign last_byte = ({1'b0, idx_q} == (nbytes_q - 3'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = req_err ? ST_RESPOND : ST_ACCESS;
      ST_ACCESS:  if (last_byte) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      bytes_q  <= '0;
      nbytes_q <= 3'd1;
      idx_q    <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        addr_q   <= req_addr[RAM_AW-1:0];
        wdata_q  <= req_wdata;
        bytes_q  <= '0;
        nbytes_q <= req_nbytes;
        idx_q    <= '0;
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= req_err;
      end else if (state_q == ST_ACCESS) begin
        if (!write_q) bytes_q[{idx_q, 3'b000} +: 8] <= ram_rdata;
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  mem_load_extend u_extend (
    .data      (bytes_q),
    .nbytes    (nbytes_q),
    .is_signed (signed_q),
    .rdata     (ext_rdata)
  );

  always_comb begin
    busy      = (state_q == ST_ACCESS);
    rsp_valid = (state_q == ST_RESPOND);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !write_q) ? ext_rdata : 32'd0;
    ram_we    = (state_q == ST_ACCESS) && write_q;
    ram_addr  = (state_q == ST_ACCESS) ? addr_q + {{(RAM_AW-2){1'b0}}, idx_q} : '0;
    ram_wdata = ram_we ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
  end

endmodule
